// File: rtl/gumnut_alu_ctrl.sv
// rtl/gumnut_alu_ctrl.sv - Gumnut ALU sequencer: fetch/decode/exec/writeback, owns GPRs and CC flags.
// Optional GUMNUT_CTRL_PERF_EN adds retired_cnt / illegal_cnt performance counters.
module gumnut_alu_ctrl #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int IW    = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [IW-1:0] alu_ir,
  output logic [DW-1:0] alu_rs,
  output logic [DW-1:0] alu_r2,
  output logic          alu_cc_c,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_c,
  output logic          done,
  output logic          illegal,
  output logic          cc_c,
  output logic          cc_z,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef GUMNUT_CTRL_PERF_EN
  ,
  output logic [15:0]   retired_cnt,
  output logic [7:0]    illegal_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  state_t        state, next_state;
  logic [IW-1:0] ir_q;
  logic [DW-1:0] op_a, op_b, res_q;
  logic          res_c;
  logic [DW-1:0] gpr [NREGS];

  logic       cls_imm, cls_reg, cls_shf, is_illegal, is_logic;
  logic [2:0] rd, rs, r2;

  assign cls_imm    = ~ir_q[17];
  assign cls_reg    = (ir_q[17:14] == 4'b1110);
  assign cls_shf    = (ir_q[17:15] == 3'b110);
  assign is_illegal = ~(cls_imm | cls_reg | cls_shf);
  // Logic functions (fn 4-7) leave the carry flag alone; fn MSB sits in a different field per class.
  assign is_logic   = (cls_imm & ir_q[16]) | (cls_reg & ir_q[2]);
  assign rd         = ir_q[13:11];
  assign rs         = ir_q[10:8];
  assign r2         = ir_q[7:5];

  assign alu_ir   = ir_q;
  assign alu_rs   = op_a;
  assign alu_r2   = op_b;
  // Flags only change in WB, so this is always the pre-instruction carry.
  assign alu_cc_c = cc_c;
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : gpr[dbg_addr];

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        instr_ready = run & ~rst;
        if (instr_valid && instr_ready) next_state = DECODE;
      end
      DECODE: begin
        if (is_illegal) begin
          illegal    = ~rst;
          next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC:    next_state = WB;
      WB: begin
        done       = ~rst;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      ir_q  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res_q <= '0;
      res_c <= 1'b0;
      cc_c  <= 1'b0;
      cc_z  <= 1'b0;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        FETCH: if (instr_valid && instr_ready) ir_q <= instr;
        DECODE: begin
          // gpr[0] is never written, so reading r0 naturally yields 0.
          op_a <= gpr[rs];
          op_b <= cls_reg ? gpr[r2] : '0;
        end
        EXEC: begin
          res_q <= alu_result;
          res_c <= alu_c;
        end
        WB: begin
          if (rd != 3'd0) gpr[rd] <= res_q;
          cc_z <= (res_q == '0);
          if (!is_logic) cc_c <= res_c;
        end
        default: ;
      endcase
    end
  end

`ifdef GUMNUT_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (done) retired_cnt <= retired_cnt + 16'd1;
      if (illegal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end
`endif

endmodule
